// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants and types for the 4-channel TDM demultiplexer.
//   CHANNELS    number of time-division channels per frame
//   SEL_W       width of the slot select / slot counter
//   tdm_state_t alignment state (UNLOCKED until the first sync, then RUN)
//   cyc_width() width of a counter that holds 0..n-1 (at least 1 bit)
package tdm_pkg;

    localparam int unsigned CHANNELS = 4;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        RUN      = 1'b1
    } tdm_state_t;

    function automatic int unsigned cyc_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdm_slot_timer.sv
// tdm_slot_timer: cycle-within-slot and slot-within-frame counters.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           advance the counters by one cycle
//   load         realign: the current cycle becomes cycle 0 of slot 0, so the
//                counters move to cycle 1 of slot 0 (has priority over en)
//   slot         current slot index 0..CHANNELS-1
//   cyc          current cycle index 0..SLOT_CYCLES-1 within the slot
//   sample_tick  current cycle is the sample cycle of the slot
//   frame_end    current cycle is the last cycle of the last slot
module tdm_slot_timer
    import tdm_pkg::*;
#(
    parameter int unsigned SLOT_CYCLES = 4,
    parameter int unsigned SAMPLE_AT   = 2,
    localparam int unsigned CYC_W      = cyc_width(SLOT_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    output logic [SEL_W-1:0] slot,
    output logic [CYC_W-1:0] cyc,
    output logic             sample_tick,
    output logic             frame_end
);

    localparam logic [CYC_W-1:0] CycLast   = CYC_W'(SLOT_CYCLES - 1);
    localparam logic [CYC_W-1:0] CycSample = CYC_W'(SAMPLE_AT);
    localparam logic [SEL_W-1:0] SlotLast  = SEL_W'(CHANNELS - 1);

    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [SEL_W-1:0] slot_q, slot_d;

    always_comb begin
        cyc_d  = cyc_q;
        slot_d = slot_q;
        if (load) begin
            cyc_d  = CYC_W'(1);
            slot_d = '0;
        end else if (en) begin
            if (cyc_q == CycLast) begin
                cyc_d  = '0;
                // Slot counter is exactly SEL_W bits wide, so it wraps modulo 4.
                slot_d = slot_q + SEL_W'(1);
            end else begin
                cyc_d = cyc_q + CYC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q  <= '0;
            slot_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            slot_q <= slot_d;
        end
    end

    assign slot        = slot_q;
    assign cyc         = cyc_q;
    assign sample_tick = (cyc_q == CycSample);
    assign frame_end   = (cyc_q == CycLast) && (slot_q == SlotLast);

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: time-division demultiplexer for a 4-channel single-bit stream.
// Aligns to a frame-sync pulse, regenerates the slot select, samples din once
// per slot and presents each complete frame as a parallel word.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en          count/sample enable; low freezes all state
//   sync        frame marker; its cycle is cycle 0 of slot 0
//   din         multiplexed serial line
//   sel_out     current slot index (drives an external 4:1 mux in loopback)
//   q           last complete frame, q[k] = slot-k sample
//   valid       one-cycle pulse after q is updated
//   locked      high once aligned (state RUN)
//   sync_err    one-cycle pulse after a misaligned sync
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int unsigned SLOT_CYCLES = 4,
    parameter int unsigned SAMPLE_AT   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                sync,
    input  logic                din,
    output logic [SEL_W-1:0]    sel_out,
    output logic [CHANNELS-1:0] q,
    output logic                valid,
    output logic                locked,
    output logic                sync_err
);

    localparam int unsigned CYC_W = cyc_width(SLOT_CYCLES);
    localparam bit SampleAtZero   = (SAMPLE_AT == 0);

    if (SLOT_CYCLES < 2 || SAMPLE_AT >= SLOT_CYCLES) begin : g_param_check
        $error("tdm_demux4: need SLOT_CYCLES >= 2 and SAMPLE_AT < SLOT_CYCLES");
    end

    tdm_state_t          state;
    logic [CHANNELS-1:0] shadow;
    logic [CHANNELS-1:0] shadow_next;

    logic [SEL_W-1:0] slot;
    logic [CYC_W-1:0] cyc;
    logic             sample_tick;
    logic             frame_end;

    logic             running;
    logic             at_frame_start;
    logic             realign;
    logic             timer_en;
    logic             do_sample;
    logic [SEL_W-1:0] sample_slot;
    logic             frame_done;

    assign running        = (state == RUN);
    assign at_frame_start = (slot == '0) && (cyc == '0);
    // A sync at the frame start while running is the normal periodic marker;
    // anything else (including the first sync) realigns the counters.
    assign realign        = en && sync && (!running || !at_frame_start);
    assign timer_en       = en && running;

    tdm_slot_timer #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .SAMPLE_AT   (SAMPLE_AT)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (timer_en),
        .load        (realign),
        .slot        (slot),
        .cyc         (cyc),
        .sample_tick (sample_tick),
        .frame_end   (frame_end)
    );

    always_comb begin
        do_sample   = 1'b0;
        sample_slot = slot;
        if (realign) begin
            // The sync cycle itself is cycle 0 of slot 0, whatever the counters say.
            do_sample   = SampleAtZero;
            sample_slot = '0;
        end else if (timer_en) begin
            do_sample = sample_tick;
        end

        // Realignment wins over a coincident frame completion.
        frame_done = timer_en && !realign && frame_end;

        // When sampling in the last cycle, slot 3's bit reaches q straight from din.
        shadow_next = shadow;
        if (do_sample) begin
            shadow_next[sample_slot] = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= UNLOCKED;
            locked   <= 1'b0;
            shadow   <= '0;
            q        <= '0;
            valid    <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            valid    <= frame_done;
            sync_err <= realign && running;
            shadow   <= shadow_next;
            if (frame_done) begin
                q <= shadow_next;
            end
            if (realign) begin
                state  <= RUN;
                locked <= 1'b1;
            end
        end
    end

    assign sel_out = slot;

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;

    localparam int S  = 4;
    localparam int SA = 2;
    localparam int F  = 4 * S;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       sync;
    logic       din;
    logic [1:0] sel_out;
    logic [3:0] q;
    logic       valid;
    logic       locked;
    logic       sync_err;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 0;

    // Behavioural model: position counted in enabled cycles since alignment.
    bit         m_locked;
    int         m_pos;
    logic [3:0] m_shadow;
    logic [3:0] m_q;
    bit         m_valid;
    bit         m_err;

    tdm_demux4 #(
        .SLOT_CYCLES (S),
        .SAMPLE_AT   (SA)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync     (sync),
        .din      (din),
        .sel_out  (sel_out),
        .q        (q),
        .valid    (valid),
        .locked   (locked),
        .sync_err (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_pos    = 0;
        m_shadow = '0;
        m_q      = '0;
        m_valid  = 0;
        m_err    = 0;
    endtask

    task automatic model_edge(input logic e, input logic s, input logic d);
        bit realign;
        int p;
        m_valid = 0;
        m_err   = 0;
        if (!e) return;
        if (!m_locked && !s) return;
        realign = s && (!m_locked || (m_pos % F) != 0);
        if (realign && m_locked) m_err = 1;
        p = realign ? 0 : m_pos;
        m_locked = 1;
        if ((p % S) == SA) m_shadow[(p / S) % 4] = d;
        if (!realign && (p % F) == F - 1) begin
            m_q     = m_shadow;
            m_valid = 1;
        end
        m_pos = p + 1;
    endtask

    function automatic logic [1:0] exp_sel();
        return m_locked ? 2'((m_pos / S) % 4) : 2'd0;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            check("sel_out", 32'(sel_out), 32'(exp_sel()));
            check("q", 32'(q), 32'(m_q));
            check("valid", 32'(valid), 32'(m_valid));
            check("locked", 32'(locked), 32'(m_locked));
            check("sync_err", 32'(sync_err), 32'(m_err));
        end
    end

    // One clock: apply inputs, advance the model at the edge, return at the negedge.
    task automatic step(input logic e, input logic s, input logic d);
        en   = e;
        sync = s;
        din  = d;
        @(posedge clk);
        if (rst_n) model_edge(e, s, d);
        @(negedge clk);
    endtask

    function automatic logic din_for(input logic [3:0] bits, input int k, input bit inv);
        logic b;
        b = bits[(k / S) % 4];
        return (inv && (k % S) != SA) ? ~b : b;
    endfunction

    // A full frame starting with a sync; t counts cycles since the sync cycle.
    task automatic frame(input logic [3:0] bits, input bit inv, input int gap_at,
                         input int gap_len, input bit exp_err, input logic [3:0] prev_q,
                         input string tag);
        int t = 0;
        int vcyc = F + gap_len;
        for (int k = 0; k < F; k++) begin
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    t++;
                    check({tag, "_gap_valid"}, 32'(valid), 32'd0);
                end
            end
            step(1'b1, k == 0, din_for(bits, k, inv));
            t++;
            check({tag, "_valid"}, 32'(valid), 32'(t == vcyc));
            if (t == 1) begin
                check({tag, "_locked"}, 32'(locked), 32'd1);
                check({tag, "_sync_err"}, 32'(sync_err), 32'(exp_err));
            end
            if (gap_len == 0 && (t == 4 || t == 8 || t == 12))
                check({tag, "_sel"}, 32'(sel_out), 32'(t / 4));
            if (t < vcyc) check({tag, "_q_hold"}, 32'(q), 32'(prev_q));
        end
        check({tag, "_q"}, 32'(q), 32'(bits));
    endtask

    initial begin
        rst_n = 1'b1;
        en    = 1'b0;
        sync  = 1'b0;
        din   = 1'b0;
        model_reset();

        // 1: reset, then idle without sync.
        #2 rst_n = 1'b0;
        #1;
        check("rst_q", 32'(q), 32'd0);
        check("rst_sel", 32'(sel_out), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        @(negedge clk);
        chk_on = 1;
        step(1'b1, 1'b0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
            check("idle_sel", 32'(sel_out), 32'd0);
            check("idle_locked", 32'(locked), 32'd0);
        end

        // 2: first frame 1,0,1,1.
        frame(4'b1101, 1'b0, -1, 0, 1'b0, 4'b0000, "s2");
        // 3: same slot values, non-sample cycles inverted.
        frame(4'b1101, 1'b1, -1, 0, 1'b0, 4'b1101, "s3");

        // 4: interrupted frame with zeros, misaligned sync in slot 2.
        step(1'b1, 1'b1, 1'b0);
        for (int k = 1; k < 9; k++) begin
            step(1'b1, 1'b0, 1'b0);
            check("s4_partial_valid", 32'(valid), 32'd0);
        end
        check("s4_slot2", 32'(sel_out), 32'd2);
        frame(4'b0101, 1'b0, -1, 0, 1'b1, 4'b1101, "s4");

        // 5: en low for 3 cycles during slot 1.
        frame(4'b1010, 1'b0, 5, 3, 1'b0, 4'b0101, "s5");

        // 6: reset in slot 3, then a fresh frame 0,1,1,0.
        step(1'b1, 1'b1, 1'b1);
        for (int k = 1; k < 13; k++) step(1'b1, 1'b0, 1'b1);
        check("s6_slot3", 32'(sel_out), 32'd3);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("s6_rst_q", 32'(q), 32'd0);
        check("s6_rst_sel", 32'(sel_out), 32'd0);
        check("s6_rst_valid", 32'(valid), 32'd0);
        check("s6_rst_locked", 32'(locked), 32'd0);
        check("s6_rst_err", 32'(sync_err), 32'd0);
        @(negedge clk);
        step(1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
            check("s6_no_valid", 32'(valid), 32'd0);
        end
        frame(4'b0110, 1'b0, -1, 0, 1'b0, 4'b0000, "s6");

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic e, s, d;
            e = ($urandom_range(0, 9) != 0);
            s = ($urandom_range(0, 59) == 0);
            if (m_locked && (m_pos % F) == 0 && $urandom_range(0, 1) == 1) s = 1'b1;
            d = 1'($urandom_range(0, 1));
            step(e, s, d);
        end

        chk_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Time-division demultiplexer for a 4-channel single-bit stream: the inverse of the team's 4:1 multiplexer when that multiplexer's select is stepped through 0..3 at a fixed slot rate. The block aligns to a frame-sync pulse and regenerates the 2-bit slot select. It samples the serial line once per slot and presents the four recovered channel bits as a parallel word with a one-cycle valid strobe. It sits at the receiving end of a multiplexed link, or in loopback with `sel_out` driving the multiplexer's select.

## Interface
Parameters:
- `SLOT_CYCLES`, default 4: clock cycles per channel slot; legal range ≥ 2.
- `SAMPLE_AT`, default 2: cycle index within a slot at which `din` is sampled; legal range 0..SLOT_CYCLES-1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  count/sample enable; low freezes all state.
- `sync`  in  1  frame marker; the cycle in which it is high is cycle 0 of slot 0.
- `din`  in  1  multiplexed serial line.
- `sel_out`  out  2  current slot index.
- `q`  out  4  last complete frame; `q[k]` is the slot-k sample.
- `valid`  out  1  one-cycle pulse; `q` was updated at the preceding edge.
- `locked`  out  1  high while aligned (state RUN).
- `sync_err`  out  1  one-cycle pulse on a misaligned sync.

## Operation
- Reset, asynchronous on `rst_n` low:
  - State goes to UNLOCKED.
  - Slot counter, cycle counter, shadow register, `q`, `sel_out`, `valid`, `locked` and `sync_err` all go to 0.
- All behaviour below requires `en`=1. With `en`=0:
  - Counters, state, shadow register and `q` hold.
  - `sync` is ignored and `din` is not sampled.
  - `valid` and `sync_err` are 0.
- UNLOCKED state:
  - The block waits for `sync`.
  - On an edge with `sync`=1, state goes to RUN, the cycle counter is loaded with 1 and the slot counter stays 0. The sync cycle therefore counts as cycle 0 of slot 0.
- RUN state:
  - The cycle counter counts 0..SLOT_CYCLES-1 and wraps to 0.
  - On each wrap the slot counter increments modulo 4.
  - At the edge that ends cycle `SAMPLE_AT` of slot k, `din` is stored into `shadow[k]`.
- Frame completion, at the edge that ends the last cycle of slot 3:
  - `q` is loaded from `shadow`. If `SAMPLE_AT` = SLOT_CYCLES-1, bit 3 is taken directly from `din` at that edge.
  - `valid` is high for the following cycle.
  - The shadow register is not cleared.
- Sync while in RUN:
  - Aligned case: `sync` arrives in a cycle where slot=0 and cycle=0. This is the normal periodic marker; there is no error and no change.
  - Misaligned case: any other position.
    - `sync_err` pulses in the next cycle.
    - Counters realign as in UNLOCKED, so the sync cycle becomes cycle 0 of slot 0.
    - The partial frame is discarded: no `valid` is produced for it and `q` holds its old value.
  - If a misaligned sync coincides with the frame-completion edge, realignment wins: there is no `valid` and `q` is not updated.
- `sel_out` always equals the slot counter.
- `locked` equals (state == RUN). Once in RUN, the block leaves it only through reset.

## Timing
- `din` is sampled exactly once per slot. Transitions of `din` on non-sample cycles have no effect.
- Latency from sync to valid:
  - Taking the sync cycle as cycle 0, `valid` is high in cycle 4·SLOT_CYCLES.
  - That cycle is also cycle 0 of the next frame.
  - With default parameters this is cycle 16.
- Steady state:
  - One `valid` pulse per 4·SLOT_CYCLES enabled cycles.
  - `q` is stable between pulses.
- `sel_out` changes at the edge that starts each slot. An external multiplexer driven by `sel_out` has SLOT_CYCLES-1 cycles of settling margin before sampling when `SAMPLE_AT` = SLOT_CYCLES-1. With the default `SAMPLE_AT`=2 the margin is 2 cycles.
- An `en`=0 stretch of N cycles delays every subsequent event by exactly N cycles.
- A reset mid-frame discards everything. A fresh `sync` is then required before any further `valid`.

## Structure
- Package `tdm_pkg`:
  - `CHANNELS` = 4.
  - `SEL_W` = 2.
  - State enum `tdm_state_t` with values UNLOCKED and RUN.
- Sub-module `tdm_slot_timer`:
  - Contains the cycle and slot counters.
  - Inputs: `en`, `load`.
  - Outputs: `slot`, `cyc`, `sample_tick`, `frame_end`.
- The top level holds the FSM, the shadow and output registers, and the sync alignment check.
- Elaboration-time assertion that `SLOT_CYCLES` ≥ 2 and `SAMPLE_AT` < `SLOT_CYCLES`.

## Test plan
All scenarios use the defaults `SLOT_CYCLES`=4 and `SAMPLE_AT`=2.
1. Hold `rst_n` low, then release. Required: `q`=0000, `sel_out`=00, `valid`=0, `locked`=0, and `sel_out` stays 00 until a `sync` arrives.
2. Pulse `sync`, then drive `din`=1, 0, 1, 1 for slots 0..3. Required:
   - `locked`=1 from cycle 1.
   - `sel_out` steps 0→1→2→3 at cycles 4, 8 and 12.
   - `valid` is high only in cycle 16, with `q`=4'b1101.
3. Keep the slot values of scenario 2 but invert `din` on every non-sample cycle. Required: `q`=4'b1101 still.
4. Pulse `sync` in slot 2 of a running frame. Required:
   - `sync_err` pulses one cycle later.
   - No `valid` for the interrupted frame and `q` keeps its previous value.
   - The next `valid` arrives 16 cycles after the new sync.
5. Drop `en` for 3 cycles during slot 1. Required: `valid` arrives at cycle 19, with the data correct.
6. Assert `rst_n` low in slot 3, then send a new frame with `din`=0, 1, 1, 0 per slot. Required:
   - All outputs are 0 immediately on reset.
   - No `valid` until a new `sync`.
   - The next frame yields `q`=4'b0110.
